// File: rtl/bip_tx_reporter.sv
// -----------------------------------------------------------------------------
// bip_tx_reporter
//
// Run/report sequencer that sits between the BIP accumulator CPU and the UART
// transmitter. It enables the CPU and counts run cycles until the CPU halts.
// It then latches ACC, PC and the cycle count and streams a 9-byte frame
// through the UART start/done handshake:
//   HEADER, ACC[15:8], ACC[7:0], PC[15:8], PC[7:0],
//   CNT[31:24], CNT[23:16], CNT[15:8], CNT[7:0]
// When the frame is complete the block idles in DONE. A restart pulse runs
// the CPU again.
//
// Ports:
//   i_clock    - system clock, rising edge
//   i_reset    - asynchronous reset, active-low
//   i_halt     - CPU halt flag (level), sampled only in RUN
//   i_acc      - CPU accumulator
//   i_pc       - CPU program counter (zero-extended to 16 bits in the frame)
//   i_restart  - one-cycle pulse, reruns the CPU (honoured only in DONE)
//   i_tx_done  - one-cycle pulse from UART tx (honoured only in WAIT)
//   o_cpu_en   - CPU clock enable
//   o_tx_start - one-cycle pulse, UART loads o_tx_data
//   o_tx_data  - byte to transmit (held between starts)
//   o_busy     - frame transmission in progress
//   o_done     - frame sent, idle
//   o_error    - UART timeout abort occurred (sticky until restart/reset)
// -----------------------------------------------------------------------------
module bip_tx_reporter #(
  parameter int unsigned BITS        = 16,
  parameter int unsigned ADDR_LENGTH = 11,
  parameter int unsigned CNT_BITS    = 32,
  parameter int unsigned TIMEOUT     = 20000,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_halt,
  input  logic [BITS-1:0]        i_acc,
  input  logic [ADDR_LENGTH-1:0] i_pc,
  input  logic                   i_restart,
  input  logic                   i_tx_done,
  output logic                   o_cpu_en,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    RUN_WAIT,
    RUN,
    SEND,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [15:0]       acc_lat_q, acc_lat_d;
  logic [15:0]       pc_lat_q, pc_lat_d;
  logic [31:0]       cnt_lat_q, cnt_lat_d;
  logic              cpu_en_q, cpu_en_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        frame_byte;

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    acc_lat_d = acc_lat_q;
    pc_lat_d  = pc_lat_q;
    cnt_lat_d = cnt_lat_q;
    error_d   = error_q;

    case (state_q)
      RUN_WAIT: state_d = RUN;

      RUN: begin
        if (i_halt) begin
          // The halt cycle itself is not counted.
          acc_lat_d = 16'(i_acc);
          pc_lat_d  = 16'(i_pc);
          cnt_lat_d = 32'(cnt_q);
          idx_d     = '0;
          state_d   = SEND;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end

      SEND: begin
        tmo_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (i_tx_done) begin
          if (idx_q == 4'd8) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      DONE: begin
        if (i_restart) begin
          cnt_d   = '0;
          error_d = 1'b0;
          state_d = RUN;
        end
      end

      default: state_d = RUN_WAIT;
    endcase
  end

  // Frame byte selected from the next-cycle index and latches so that the
  // first byte can be loaded on the same edge that leaves RUN.
  always_comb begin
    case (idx_d)
      4'd0:    frame_byte = HEADER;
      4'd1:    frame_byte = acc_lat_d[15:8];
      4'd2:    frame_byte = acc_lat_d[7:0];
      4'd3:    frame_byte = pc_lat_d[15:8];
      4'd4:    frame_byte = pc_lat_d[7:0];
      4'd5:    frame_byte = cnt_lat_d[31:24];
      4'd6:    frame_byte = cnt_lat_d[23:16];
      4'd7:    frame_byte = cnt_lat_d[15:8];
      4'd8:    frame_byte = cnt_lat_d[7:0];
      default: frame_byte = '0;
    endcase
  end

  // Registered outputs are decoded from the next state.
  always_comb begin
    cpu_en_d   = (state_d == RUN);
    tx_start_d = (state_d == SEND);
    tx_data_d  = (state_d == SEND) ? frame_byte : tx_data_q;
    busy_d     = (state_d == SEND) || (state_d == WAIT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= RUN_WAIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      acc_lat_q  <= '0;
      pc_lat_q   <= '0;
      cnt_lat_q  <= '0;
      cpu_en_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      acc_lat_q  <= acc_lat_d;
      pc_lat_q   <= pc_lat_d;
      cnt_lat_q  <= cnt_lat_d;
      cpu_en_q   <= cpu_en_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign o_cpu_en   = cpu_en_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule
